debouncer_array: RTL and testbench

DEBOUNCER_ARRAY -- requirements
Module: debouncer_array

---
 rtl/debouncer_array.sv | 80 ++++++++
 tb/tb_debouncer_array.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_array.sv
// Per-channel push-button debouncer: 2-flop sync, 2^CNT_W-cycle stability filter, press/release/long-press pulses.
// Press/release pulses are combinational in the cycle before pb_state toggles; pb_long is registered; no backpressure.
module debouncer_array #(
   parameter int CHANNELS   = 4,
   parameter int CNT_W      = 16,
   parameter int HOLD_W     = 8,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] pb,
   output logic [CHANNELS-1:0] pb_state,
   output logic [CHANNELS-1:0] pb_down,
   output logic [CHANNELS-1:0] pb_up,
   output logic [CHANNELS-1:0] pb_long,
   output logic                any_pressed
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = ~HOLD_W'(1);

   logic [CHANNELS-1:0] pb_norm;

   assign pb_norm     = ACTIVE_LOW ? ~pb : pb;
   assign any_pressed = |pb_state;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic              sync0, sync1, state, long_q;
      logic [CNT_W-1:0]  cnt;
      logic [CNT_W-1:0]  pre;
      logic [HOLD_W-1:0] hold;
      logic              idle, toggle, state_nxt, tick, long_hit;

      assign idle      = (state == sync1);
      assign toggle    = ~idle & (&cnt);
      assign state_nxt = state ^ toggle;
      // The hold prescaler runs only while pressed, giving one tick per 2^CNT_W cycles of pb_state==1.
      assign tick      = state & (&pre);
      assign long_hit  = tick & state_nxt & (hold == HOLD_LAST);

      assign pb_state[i] = state;
      assign pb_down[i]  = toggle & ~state;
      assign pb_up[i]    = toggle & state;
      assign pb_long[i]  = long_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            state  <= 1'b0;
            cnt    <= '0;
            pre    <= '0;
            hold   <= '0;
            long_q <= 1'b0;
         end else begin
            sync0  <= pb_norm[i];
            sync1  <= sync0;
            state  <= state_nxt;
            long_q <= long_hit;

            if (idle || (&cnt)) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end

            // Clearing on the edge where pb_state falls keeps hold at 0 in every released cycle.
            if (!state_nxt) begin
               pre  <= '0;
               hold <= '0;
            end else if (state) begin
               pre <= pre + 1'b1;
               if (tick && !(&hold)) begin
                  hold <= hold + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_debouncer_array.sv
// Randomised and directed bench for debouncer_array; one active-low and one active-high instance share a run-length reference model.
module tb_debouncer_array;

   localparam int CH     = 4;
   localparam int CNT_W  = 4;
   localparam int HOLD_W = 2;
   localparam int DEB    = 2 ** CNT_W;
   localparam int LONG   = (2 ** HOLD_W - 1) * DEB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] pb_a = '1;
   logic [CH-1:0] pb_b;
   logic [CH-1:0] st_a, dn_a, up_a, lg_a;
   logic [CH-1:0] st_b, dn_b, up_b, lg_b;
   logic          any_a, any_b;

   assign pb_b = ~pb_a;

   always #5 clk = ~clk;

   debouncer_array #(.CHANNELS(CH), .CNT_W(CNT_W), .HOLD_W(HOLD_W), .ACTIVE_LOW(1'b1)) u_dut_lo (
      .clk(clk), .rst(rst), .pb(pb_a), .pb_state(st_a), .pb_down(dn_a),
      .pb_up(up_a), .pb_long(lg_a), .any_pressed(any_a)
   );

   debouncer_array #(.CHANNELS(CH), .CNT_W(CNT_W), .HOLD_W(HOLD_W), .ACTIVE_LOW(1'b0)) u_dut_hi (
      .clk(clk), .rst(rst), .pb(pb_b), .pb_state(st_b), .pb_down(dn_b),
      .pb_up(up_b), .pb_long(lg_b), .any_pressed(any_b)
   );

   int vectors = 0;
   int miscompares = 0;
   int tick_no = 0;

   // Reference model: sampled input history, debounced level, length of the current
   // disagreement run, and how many cycles the channel has been reported pressed.
   bit m_s0 [CH];
   bit m_s1 [CH];
   bit m_state [CH];
   int m_run [CH];
   int m_age [CH];

   logic [CH-1:0] obs_st, obs_dn, obs_up, obs_lg;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_s0[c] = 0; m_s1[c] = 0; m_state[c] = 0; m_run[c] = 0; m_age[c] = 0;
      end
   endtask

   // Compare one cycle at the falling edge, then advance the model to the next rising edge.
   task automatic tick();
      logic [CH-1:0] e_st, e_dn, e_up, e_lg;
      int run_cur [CH];
      bit nstate;
      @(negedge clk);
      tick_no++;
      for (int c = 0; c < CH; c++) begin
         run_cur[c] = (m_s1[c] != m_state[c]) ? m_run[c] + 1 : 0;
         e_st[c] = m_state[c];
         e_dn[c] = (run_cur[c] == DEB) && !m_state[c];
         e_up[c] = (run_cur[c] == DEB) && m_state[c];
         e_lg[c] = m_state[c] && (m_age[c] == LONG + 1);
      end
      check("state_lo", 32'(st_a), 32'(e_st));
      check("down_lo",  32'(dn_a), 32'(e_dn));
      check("up_lo",    32'(up_a), 32'(e_up));
      check("long_lo",  32'(lg_a), 32'(e_lg));
      check("any_lo",   32'(any_a), 32'(|e_st));
      check("state_hi", 32'(st_b), 32'(e_st));
      check("down_hi",  32'(dn_b), 32'(e_dn));
      check("up_hi",    32'(up_b), 32'(e_up));
      check("long_hi",  32'(lg_b), 32'(e_lg));
      check("any_hi",   32'(any_b), 32'(|e_st));
      check("up_and_down", 32'(dn_a & up_a), 32'd0);
      obs_st = st_a; obs_dn = dn_a; obs_up = up_a; obs_lg = lg_a;
      if (rst) begin
         model_reset();
      end else begin
         for (int c = 0; c < CH; c++) begin
            nstate = (run_cur[c] == DEB) ? !m_state[c] : m_state[c];
            m_run[c] = (run_cur[c] == DEB) ? 0 : run_cur[c];
            m_age[c] = nstate ? (m_state[c] ? m_age[c] + 1 : 1) : 0;
            m_state[c] = nstate;
            m_s1[c] = m_s0[c];
            m_s0[c] = ~pb_a[c];
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic check_reset_outputs();
      check("rst_state_lo", 32'(st_a), 32'd0);
      check("rst_down_lo",  32'(dn_a), 32'd0);
      check("rst_up_lo",    32'(up_a), 32'd0);
      check("rst_long_lo",  32'(lg_a), 32'd0);
      check("rst_any_lo",   32'(any_a), 32'd0);
      check("rst_state_hi", 32'(st_b), 32'd0);
      check("rst_down_hi",  32'(dn_b), 32'd0);
      check("rst_any_hi",   32'(any_b), 32'd0);
   endtask

   initial begin
      int first, t_state, t_long, n_dn, n_up, n_lg, n_any, sim_val, guard;
      int seg_left [CH];
      bit seg_lvl [CH];
      bit b;

      model_reset();
      ticks(3);
      check_reset_outputs();
      rst = 1'b0;
      ticks(5);

      // Single press on channel 0: pulse cycle and width.
      pb_a[0] = 1'b0;
      first = 0; n_dn = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (obs_dn[0]) begin
            n_dn++;
            if (first == 0) first = k;
         end
      end
      check("press_latency", 32'(first), 32'(DEB + 2));
      check("press_pulses", 32'(n_dn), 32'd1);
      pb_a[0] = 1'b1;
      ticks(30);

      // Long press on channel 2, then release.
      pb_a[2] = 1'b0;
      t_state = 0; t_long = 0; n_lg = 0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (obs_st[2] && t_state == 0) t_state = k;
         if (obs_lg[2]) begin
            n_lg++;
            if (t_long == 0) t_long = k;
         end
      end
      check("long_delay", 32'(t_long - t_state), 32'(LONG));
      check("long_pulses", 32'(n_lg), 32'd1);
      pb_a[2] = 1'b1;
      n_up = 0; n_lg = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (obs_up[2]) n_up++;
         if (obs_lg[2]) n_lg++;
      end
      check("release_up_pulses", 32'(n_up), 32'd1);
      check("release_no_long", 32'(n_lg), 32'd0);

      // Bouncing channel 1: 10-cycle lows separated by single highs never settle.
      n_any = 0;
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 11; k++) begin
            pb_a[1] = (k == 10);
            tick();
            if (obs_st[1] || obs_dn[1] || obs_up[1] || obs_lg[1]) n_any++;
         end
      end
      pb_a[1] = 1'b1;
      ticks(25);
      check("bounce_quiet", 32'(n_any), 32'd0);

      // Channels 0 and 3 pressed together.
      pb_a = 4'b0110;
      sim_val = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (obs_dn != 0 && sim_val == 0) sim_val = 32'(obs_dn);
      end
      check("simul_down", 32'(sim_val), 32'h9);
      pb_a = '1;
      ticks(30);

      // Reset part-way through a count discards it; held press is re-detected afterwards.
      pb_a[0] = 1'b0;
      guard = 0;
      while (!(m_s1[0] != m_state[0] && m_run[0] + 1 == 13) && guard < 40) begin
         tick();
         guard++;
      end
      check("reach_count_12", 32'(guard < 40), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs();
      model_reset();
      ticks(2);
      rst = 1'b0;
      first = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (obs_dn[0] && first == 0) first = k;
      end
      check("reset_press_latency", 32'(first), 32'(DEB + 2));
      pb_a = '1;
      ticks(30);

      // Random segments with occasional single-cycle glitches on every channel.
      for (int c = 0; c < CH; c++) seg_left[c] = 0;
      for (int k = 0; k < 3000; k++) begin
         for (int c = 0; c < CH; c++) begin
            if (seg_left[c] == 0) begin
               seg_lvl[c]  = 1'($urandom_range(0, 1));
               seg_left[c] = $urandom_range(1, 90);
            end
            seg_left[c]--;
            b = seg_lvl[c];
            if ($urandom_range(0, 24) == 0) b = ~b;
            pb_a[c] = ~b;
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
